clock_time_ctrl: RTL and testbench

Sequencing and setting controller for the clock-calendar timekeeping chain: seconds (0–59), minutes (0–59), and the 0–23 BCD hour counter. All three counters share the system clock `CP`. This block generates their one-cycle `EN` strobes in normal running (the carry chain) and in time-setting mode (debounced key increments). It also owns the mode state machine, the seconds clear, and the display blink flags.

---
 rtl/clock_time_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Sequencing and setting controller for the seconds/minutes/hours chain.
// Define CLOCK_CTRL_AUTO_REPEAT_EN to build in auto-repeat for a held adjust key.
module clock_time_ctrl #(
    parameter int unsigned DB_CYCLES     = 20,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned RPT_DELAY     = 500,
    parameter int unsigned RPT_PERIOD    = 200
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       Tick,
    input  logic       KeyMode,
    input  logic       KeyAdj,
    input  logic       SecMax,
    input  logic       MinMax,
    input  logic       HourMax,
    output logic       SecEN,
    output logic       MinEN,
    output logic       HourEN,
    output logic       DayCarry,
    output logic       nSecCR,
    output logic [1:0] Mode,
    output logic       BlinkH,
    output logic       BlinkM
);

    localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    state_e state_q, state_d;

    // Key front end; index 0 is KeyMode, index 1 is KeyAdj.
    logic [1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]     level_q, level_d, press_q, press_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];

    logic            mode_press, adj_press, adj_inc, setting, timeout;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            phase_q, phase_d;
    logic            sec_en_q, sec_en_d, min_en_q, min_en_d;
    logic            hour_en_q, hour_en_d, day_carry_q, day_carry_d;
    logic            n_sec_cr_q, n_sec_cr_d, blink_h_q, blink_h_d, blink_m_q, blink_m_d;

    always_comb begin
        sync1_d = {KeyAdj, KeyMode};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            level_d[i]  = level_q[i];
            press_d[i]  = 1'b0;
            db_cnt_d[i] = '0;
            // A new level is accepted only after DB_CYCLES consecutive differing samples.
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            press_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign mode_press = press_q[0];
    assign adj_press  = press_q[1];
    assign setting    = (state_q != StRun);

`ifdef CLOCK_CTRL_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_on_q, rpt_on_d;
    logic            rpt_fire;

    // rpt_on_q marks that the initial RPT_DELAY has elapsed; later repeats use RPT_PERIOD.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
        rpt_fire  = 1'b0;
        if (!adj_press && level_q[1] && setting && !mode_press) begin
            rpt_on_d = rpt_on_q;
            if (( rpt_on_q && rpt_cnt_q == RptW'(RPT_PERIOD - 1)) ||
                (!rpt_on_q && rpt_cnt_q == RptW'(RPT_DELAY - 1))) begin
                rpt_fire = 1'b1;
                rpt_on_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            rpt_cnt_q <= '0;
            rpt_on_q  <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_on_q  <= rpt_on_d;
        end
    end

    assign adj_inc = adj_press | rpt_fire;
`else
    logic unused_rpt;
    assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
    assign adj_inc    = adj_press;
`endif

    // Timeout tick counter; cleared outside setting modes and on every key event.
    always_comb begin
        tmo_d   = tmo_q;
        timeout = 1'b0;
        if (!setting || mode_press || adj_inc) begin
            tmo_d = '0;
        end else if (Tick && TIMEOUT_TICKS != 0) begin
            if (tmo_q == TmoW'(TIMEOUT_TICKS - 1)) begin
                timeout = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q <= StRun;
            tmo_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            phase_q <= phase_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                default:   state_d = StRun;
            endcase
        end else if (timeout) begin
            state_d = StRun;
        end
    end

    // FSM: outputs, all registered below.
    always_comb begin
        sec_en_d    = 1'b0;
        min_en_d    = 1'b0;
        hour_en_d   = 1'b0;
        day_carry_d = 1'b0;
        n_sec_cr_d  = !(state_q == StSetMin && state_d == StRun);
        case (state_q)
            StRun: begin
                if (Tick) begin
                    sec_en_d    = 1'b1;
                    min_en_d    = SecMax;
                    hour_en_d   = SecMax & MinMax;
                    day_carry_d = SecMax & MinMax & HourMax;
                end
            end
            StSetHour: hour_en_d = adj_inc & ~mode_press;
            StSetMin:  min_en_d  = adj_inc & ~mode_press;
            default: ;
        endcase
        if (state_d != state_q) begin
            phase_d = 1'b0;
        end else begin
            phase_d = phase_q ^ Tick;
        end
        blink_h_d = (state_d == StSetHour) & phase_d;
        blink_m_d = (state_d == StSetMin) & phase_d;
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sec_en_q    <= 1'b0;
            min_en_q    <= 1'b0;
            hour_en_q   <= 1'b0;
            day_carry_q <= 1'b0;
            n_sec_cr_q  <= 1'b1;
            blink_h_q   <= 1'b0;
            blink_m_q   <= 1'b0;
        end else begin
            sec_en_q    <= sec_en_d;
            min_en_q    <= min_en_d;
            hour_en_q   <= hour_en_d;
            day_carry_q <= day_carry_d;
            n_sec_cr_q  <= n_sec_cr_d;
            blink_h_q   <= blink_h_d;
            blink_m_q   <= blink_m_d;
        end
    end

    assign SecEN    = sec_en_q;
    assign MinEN    = min_en_q;
    assign HourEN   = hour_en_q;
    assign DayCarry = day_carry_q;
    assign nSecCR   = n_sec_cr_q;
    assign Mode     = state_q;
    assign BlinkH   = blink_h_q;
    assign BlinkM   = blink_m_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl (DB_CYCLES=20, TIMEOUT_TICKS=3).
module tb_clock_time_ctrl;

    localparam int DB = 20;

    logic       CP = 1'b0;
    logic       nCR = 1'b1;
    logic       Tick = 1'b0, KeyMode = 1'b0, KeyAdj = 1'b0;
    logic       SecMax = 1'b0, MinMax = 1'b0, HourMax = 1'b0;
    logic       SecEN, MinEN, HourEN, DayCarry, nSecCR, BlinkH, BlinkM;
    logic [1:0] Mode;

    clock_time_ctrl #(
        .DB_CYCLES    (DB),
        .TIMEOUT_TICKS(3),
        .RPT_DELAY    (50),
        .RPT_PERIOD   (20)
    ) dut (
        .CP      (CP),
        .nCR     (nCR),
        .Tick    (Tick),
        .KeyMode (KeyMode),
        .KeyAdj  (KeyAdj),
        .SecMax  (SecMax),
        .MinMax  (MinMax),
        .HourMax (HourMax),
        .SecEN   (SecEN),
        .MinEN   (MinEN),
        .HourEN  (HourEN),
        .DayCarry(DayCarry),
        .nSecCR  (nSecCR),
        .Mode    (Mode),
        .BlinkH  (BlinkH),
        .BlinkM  (BlinkM)
    );

    always #5 CP = ~CP;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_sec = 0, n_min = 0, n_hour = 0, n_day = 0, n_clr = 0, clr_bad = 0;
    int hour_t[$];

    // Pulse counters sampled mid-cycle.
    always @(negedge CP) begin
        cyc++;
        if (SecEN)    n_sec++;
        if (MinEN)    n_min++;
        if (DayCarry) n_day++;
        if (HourEN) begin
            n_hour++;
            hour_t.push_back(cyc);
        end
        if (!nSecCR) begin
            n_clr++;
            if (Mode != 2'b00) clr_bad++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic tick_once();
        Tick = 1'b1;
        step(1);
        Tick = 1'b0;
    endtask

    // which: 0 = KeyMode, 1 = KeyAdj, 2 = both together.
    task automatic press(input int which, input int hold);
        if (which != 1) KeyMode = 1'b1;
        if (which != 0) KeyAdj = 1'b1;
        step(hold);
        KeyMode = 1'b0;
        KeyAdj  = 1'b0;
        step(DB + 6);
    endtask

    int s0, m0, h0, c0, d0, k, idx;

    initial begin
        #2 nCR = 1'b0;
        step(3);
        check("rst_mode", int'(Mode), 0);
        check("rst_strobes", int'({SecEN, MinEN, HourEN, DayCarry}), 0);
        check("rst_nseccr", int'(nSecCR), 1);
        check("rst_blink", int'({BlinkH, BlinkM}), 0);
        nCR = 1'b1;
        step(2);

        // RUN carry chain.
        {SecMax, MinMax, HourMax} = 3'b111;
        tick_once();
        check("run_all_max", int'({SecEN, MinEN, HourEN, DayCarry}), 4'b1111);
        step(1);
        check("run_all_max_1cyc", int'({SecEN, MinEN, HourEN, DayCarry}), 0);
        {SecMax, MinMax, HourMax} = 3'b100;
        tick_once();
        check("run_sec_max", int'({SecEN, MinEN, HourEN, DayCarry}), 4'b1100);
        {SecMax, MinMax, HourMax} = 3'b000;
        step(2);
        tick_once();
        check("run_plain", int'({SecEN, MinEN, HourEN, DayCarry}), 4'b1000);
        {SecMax, MinMax, HourMax} = 3'b110;
        step(2);
        tick_once();
        check("run_sec_min_max", int'({SecEN, MinEN, HourEN, DayCarry}), 4'b1110);
        {SecMax, MinMax, HourMax} = 3'b000;
        step(2);

        // Tick lands in the same cycle as the KeyMode press event.
        KeyMode = 1'b1;
        step(22);
        tick_once();
        check("entry_tick_sec", int'(SecEN), 1);
        check("entry_tick_mode", int'(Mode), 1);
        KeyMode = 1'b0;
        step(DB + 6);

        // SET_HOUR: frozen time, blink.
        s0 = n_sec;
        tick_once();
        check("blink_h", int'(BlinkH), 1);
        step(2);
        check("sethour_frozen", n_sec - s0, 0);

        // Bounce rejection, then a clean 25-cycle hold with exact latency.
        h0 = n_hour;
        repeat (4) begin
            KeyAdj = 1'b1;
            step(5);
            KeyAdj = 1'b0;
            step(5);
        end
        step(DB + 5);
        check("bounce_no_hour", n_hour - h0, 0);
        KeyAdj = 1'b1;
        k = 0;
        while (!HourEN && k < 60) begin
            step(1);
            k++;
        end
        check("adj_latency", k, DB + 3);
        step(25 - k);
        KeyAdj = 1'b0;
        step(DB + 6);
        check("hold25_one_hour", n_hour - h0, 1);

        // SET_MIN adjust never carries.
        press(0, 30);
        check("setmin_mode", int'(Mode), 2);
        check("setmin_blink_cleared", int'(BlinkM), 0);
        {SecMax, MinMax, HourMax} = 3'b111;
        m0 = n_min;
        h0 = n_hour;
        d0 = n_day;
        repeat (3) press(1, 30);
        check("setmin_min3", n_min - m0, 3);
        check("setmin_hour0", n_hour - h0, 0);
        check("setmin_mode_kept", int'(Mode), 2);

        // Timeout after 3 Ticks without keys.
        s0 = n_sec;
        c0 = n_clr;
        tick_once();
        step(5);
        check("setmin_tick_no_sec", n_sec - s0, 0);
        tick_once();
        step(5);
        check("timeout_not_yet", int'(Mode), 2);
        tick_once();
        check("timeout_mode", int'(Mode), 0);
        check("timeout_nseccr", int'(nSecCR), 0);
        step(1);
        check("timeout_one_clr", n_clr - c0, 1);
        check("setting_no_daycarry", n_day - d0, 0);
        {SecMax, MinMax, HourMax} = 3'b000;

        // Simultaneous presses: mode wins, adjust dropped.
        press(0, 30);
        h0 = n_hour;
        m0 = n_min;
        press(2, 30);
        check("both_mode", int'(Mode), 2);
        check("both_no_adj", (n_hour - h0) + (n_min - m0), 0);
        c0 = n_clr;
        press(0, 30);
        check("key_exit_mode", int'(Mode), 0);
        check("key_exit_clr", n_clr - c0, 1);
        check("clr_only_with_run", clr_bad, 0);

        // Reset in the middle of SET_MIN.
        press(0, 30);
        press(0, 30);
        check("pre_reset_mode", int'(Mode), 2);
        nCR = 1'b0;
        step(2);
        check("midreset_mode", int'(Mode), 0);
        check("midreset_nseccr", int'(nSecCR), 1);
        check("midreset_strobes", int'({SecEN, MinEN, HourEN, DayCarry}), 0);
        nCR = 1'b1;
        step(2);
        tick_once();
        check("after_reset_tick", int'({SecEN, MinEN, HourEN, DayCarry}), 4'b1000);
        check("after_reset_mode", int'(Mode), 0);

        // Long hold in SET_HOUR.
        press(0, 30);
        idx = hour_t.size();
        KeyAdj = 1'b1;
        step(100);
        KeyAdj = 1'b0;
        step(DB + 10);
`ifdef CLOCK_CTRL_AUTO_REPEAT_EN
        check("rpt_count", hour_t.size() - idx, 4);
        if (hour_t.size() - idx == 4) begin
            check("rpt_off1", hour_t[idx+1] - hour_t[idx], 50);
            check("rpt_off2", hour_t[idx+2] - hour_t[idx], 70);
            check("rpt_off3", hour_t[idx+3] - hour_t[idx], 90);
        end
`else
        check("hold100_single", hour_t.size() - idx, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
